adma_desc_fetch: RTL
====================

ADMA_DESC_FETCH -- requirements
Module: adma_desc_fetch

Interface
REQ-001 SHALL have parameter RTY_MAX, default 4, meaning retries allowed per beat before declaring error (used only with ADMA_DESC_RTY_EN).
REQ-002 SHALL have port wb_clk_i  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports fetch_req in 1 (start fetch) and fetch_adr in 32 (descriptor base, byte address).
REQ-005 SHALL have port fetch_busy  out  1  high from accept until desc_valid/desc_err is acknowledged.
REQ-006 SHALL have ports desc_valid out 1, desc_err out 1, desc_ack in 1 (result handshake).
REQ-007 SHALL have outputs next_desc, ctl_addr, dc_fc, src_desc, dst_desc, each 32: parsed descriptor fields.
REQ-008 SHALL have WB master outputs wbm_adr_o 32, wbm_cyc_o 1, wbm_stb_o 1, wbm_we_o 1, wbm_cab_o 1, wbm_sel_o 4.
REQ-009 SHALL have WB master inputs wbm_ack_i 1, wbm_err_i 1, wbm_rty_i 1, wbm_dat_i 32 (low word), wbm_dat64_i 32 (high word).

Function
REQ-010 SHALL implement states IDLE, BUS, RWAIT (retry gap), DONE, ERR.
REQ-011 IDLE: fetch_req=1 at an edge -> BUS; fetch_adr latched with bits [2:0] forced to 0; beat counter cleared.
REQ-012 BUS: wbm_cyc_o=wbm_stb_o=wbm_cab_o=1, wbm_we_o=0, wbm_sel_o=4'hF, wbm_adr_o=base+8*beat (modulo 2^32, wrap permitted).
REQ-013 Descriptor SHALL be 4 beats of 64 bits: beat0 H=next_desc L=ctl_addr; beat1 H=dc_fc; beat2 H=src_desc; beat3 H=dst_desc; other L words discarded.
REQ-014 Each edge in BUS with wbm_ack_i=1 SHALL capture the beat's field(s) and increment beat; ack on beat 3 -> DONE, cyc/stb/cab low on the next cycle.
REQ-015 Zero-wait ack: req at cycle N -> cyc high N+1..N+4 -> desc_valid high from N+5.
REQ-016 DONE: desc_valid=1, fields stable, held until desc_ack=1, then IDLE next cycle; desc_ack outside DONE/ERR ignored.
REQ-017 wbm_err_i=1 in BUS -> ERR, cyc low next cycle; desc_err=1 until desc_ack; fields partial and undefined.
REQ-018 Simultaneous ack and err SHALL be treated as err; simultaneous ack and rty as rty.
REQ-019 fetch_req while fetch_busy=1 SHALL be ignored (not queued).
REQ-020 fetch_busy = (state != IDLE); fetch_req accepted in same edge as desc_ack is not allowed (IDLE first).

Reset
REQ-021 wb_rst_i=1 at an edge SHALL force IDLE, regardless of state, including mid-burst.
REQ-022 Reset values: all wbm_* outputs 0, fetch_busy 0, desc_valid 0, desc_err 0, all field outputs 32'h0, counters 0.

Configuration
REQ-023 Macro ADMA_DESC_RTY_EN defined: wbm_rty_i=1 in BUS -> RWAIT one cycle (cyc low), then BUS re-issuing same beat; per-beat retry count resets on ack; count exceeding RTY_MAX -> ERR.
REQ-024 ADMA_DESC_RTY_EN undefined: wbm_rty_i=1 in BUS treated exactly as wbm_err_i; RWAIT state absent.

Verification
REQ-025 Memory beat0 H=0x300 L=0x200, beat1 H=0x1, beat2 H=0x400, beat3 H=0x500, fetch_adr=0, ack=cyc -> next_desc=0x300, ctl_addr=0x200, dc_fc=0x1, src_desc=0x400, dst_desc=0x500, desc_valid at req+5, addresses 0x0,0x8,0x10,0x18.
REQ-026 fetch_adr=0xFFFFFFF0 -> wbm_adr_o sequence 0xFFFFFFF0, 0xFFFFFFF8, 0x0, 0x8.
REQ-027 wbm_err_i=1 on beat 2 -> cyc low next cycle, desc_err=1 until desc_ack, then fetch_busy=0.
REQ-028 With ADMA_DESC_RTY_EN, rty on beat 1 twice then ack -> beat 1 address 0x8 issued 3 times, fields correct; RTY_MAX+1 consecutive rty -> desc_err=1.
REQ-029 wb_rst_i pulsed during beat 1 -> next cycle wbm_cyc_o=0, fetch_busy=0, all fields 0; subsequent fetch completes normally.
REQ-030 fetch_req held high through DONE, desc_ack pulsed -> exactly one new fetch starts after return to IDLE.

Source files
------------

// File: rtl/adma_desc_fetch_if.sv
// Wishbone master bus bundle for the ADMA descriptor fetcher.
// master: the fetcher drives the request side; slave: memory/arbiter side.
interface adma_desc_fetch_if;
  logic [31:0] wbm_adr_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic        wbm_cab_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;
  logic [31:0] wbm_dat_i;    // low word of the 64-bit beat
  logic [31:0] wbm_dat64_i;  // high word of the 64-bit beat

  modport master (
    output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_sel_o,
    input  wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i, wbm_dat64_i
  );

  modport slave (
    input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_sel_o,
    output wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i, wbm_dat64_i
  );
endinterface

// File: rtl/adma_desc_fetch.sv
// ADMA descriptor fetcher: reads a 4-beat (4 x 64-bit) descriptor over a
// Wishbone burst and presents the parsed fields until acknowledged.
// Optional feature macro: ADMA_DESC_RTY_EN -- when defined, wbm_rty_i causes a
// one-cycle bus release and a re-issue of the same beat (up to RTY_MAX retries
// per beat); when undefined, wbm_rty_i is handled exactly like wbm_err_i.
module adma_desc_fetch #(
  parameter int RTY_MAX = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        fetch_req,
  input  logic [31:0] fetch_adr,
  output logic        fetch_busy,
  output logic        desc_valid,
  output logic        desc_err,
  input  logic        desc_ack,
  output logic [31:0] next_desc,
  output logic [31:0] ctl_addr,
  output logic [31:0] dc_fc,
  output logic [31:0] src_desc,
  output logic [31:0] dst_desc,
  adma_desc_fetch_if.master wbm
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BUS   = 3'd1;
  localparam logic [2:0] S_RWAIT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  // A negative retry budget has no meaning; no logic is built for it.
  if (RTY_MAX < 0) begin : g_rty_cfg_invalid
  end

  logic [2:0]  state;
  logic [31:0] base;
  logic [1:0]  beat;
  logic        in_bus;

`ifdef ADMA_DESC_RTY_EN
  localparam int RW = $clog2(RTY_MAX + 1) + 1;
  logic [RW-1:0] rty_cnt;
`endif

  assign in_bus     = (state == S_BUS);
  assign fetch_busy = (state != S_IDLE);
  assign desc_valid = (state == S_DONE);
  assign desc_err   = (state == S_ERR);

  // Bus request is a pure decode of the state, so it drops the cycle after
  // the last ack/err and reads zero whenever the fetcher is off the bus.
  assign wbm.wbm_cyc_o = in_bus;
  assign wbm.wbm_stb_o = in_bus;
  assign wbm.wbm_cab_o = in_bus;
  assign wbm.wbm_we_o  = 1'b0;
  assign wbm.wbm_sel_o = in_bus ? 4'hF : 4'h0;
  assign wbm.wbm_adr_o = in_bus ? (base + {27'd0, beat, 3'b000}) : 32'h0;

  // Fetch sequencer: accept, burst 4 beats, then hold result until acked.
  // Priority in BUS is err > rty > ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      base      <= 32'h0;
      beat      <= 2'd0;
      next_desc <= 32'h0;
      ctl_addr  <= 32'h0;
      dc_fc     <= 32'h0;
      src_desc  <= 32'h0;
      dst_desc  <= 32'h0;
`ifdef ADMA_DESC_RTY_EN
      rty_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_req) begin
            state <= S_BUS;
            base  <= {fetch_adr[31:3], 3'b000};
            beat  <= 2'd0;
`ifdef ADMA_DESC_RTY_EN
            rty_cnt <= '0;
`endif
          end
        end
        S_BUS: begin
          if (wbm.wbm_err_i) begin
            state <= S_ERR;
          end else if (wbm.wbm_rty_i) begin
`ifdef ADMA_DESC_RTY_EN
            if (rty_cnt >= RW'(RTY_MAX)) begin
              state <= S_ERR;
            end else begin
              rty_cnt <= rty_cnt + RW'(1);
              state   <= S_RWAIT;
            end
`else
            state <= S_ERR;
`endif
          end else if (wbm.wbm_ack_i) begin
            case (beat)
              2'd0: begin
                next_desc <= wbm.wbm_dat64_i;
                ctl_addr  <= wbm.wbm_dat_i;
              end
              2'd1: dc_fc    <= wbm.wbm_dat64_i;
              2'd2: src_desc <= wbm.wbm_dat64_i;
              default: dst_desc <= wbm.wbm_dat64_i;
            endcase
            beat <= beat + 2'd1;
`ifdef ADMA_DESC_RTY_EN
            rty_cnt <= '0;
`endif
            if (beat == 2'd3) state <= S_DONE;
          end
        end
        S_RWAIT: state <= S_BUS;
        S_DONE, S_ERR: begin
          if (desc_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
